truth_table_sweeper: RTL

Sequential characterizer for 3-input logic functions: it drives all eight input combinations into a device under characterization and samples the device's single output for each one. From those samples it rebuilds the device's 8-bit Wolfram-style function code, for example 0xD5. It is the read-back counterpart of the per-code truth-table modules: those map inputs to an output, and this block recovers the code from the output. It sits in the verification/characterization harness between a controller, which issues start/abort and consumes the code, and one truth-table instance.

---
 rtl/truth_table_sweeper.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/truth_table_sweeper.sv
// Sweeps all eight input vectors into a 3-input logic device, majority-votes its
// output per vector and rebuilds the 8-bit function code (bit for index i at [7-i]).
module truth_table_sweeper #(
  parameter int SETTLE_CYCLES = 4,
  parameter int NUM_SAMPLES   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       dut_out,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic       code_valid,
  output logic [7:0] table_code
);

  localparam int HALF = NUM_SAMPLES / 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  idx;
  logic [7:0]  settle_cnt;
  logic [3:0]  sample_cnt;
  logic [3:0]  ones_p0;
  logic [7:0]  code_sr_p0;

  logic        go;
  logic        cancel;
  logic        settle_last;
  logic        vec_last;
  logic        finish;
  logic        resolved;
  logic [7:0]  code_next;

  function automatic logic majority(input logic [3:0] ones, input logic smp);
    logic [4:0] total;
    total = {1'b0, ones} + {4'b0000, smp};
    return (total > 5'(HALF));
  endfunction

  assign settle_last = (settle_cnt == 8'(SETTLE_CYCLES - 1));
  assign resolved    = majority(ones_p0, dut_out);
  assign code_next   = {code_sr_p0[6:0], resolved};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start && !abort) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (abort)            state_nxt = IDLE;
        else if (settle_last) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        if (abort)         state_nxt = IDLE;
        else if (vec_last) state_nxt = (idx == 3'd7) ? IDLE : SETTLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control strobes
  always_comb begin
    go       = 1'b0;
    cancel   = 1'b0;
    vec_last = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE:    go = start && !abort;
      SETTLE:  cancel = abort;
      SAMPLE: begin
        cancel   = abort;
        vec_last = !abort && (sample_cnt == 4'(NUM_SAMPLES - 1));
        finish   = !abort && (sample_cnt == 4'(NUM_SAMPLES - 1)) && (idx == 3'd7);
      end
      default: begin
        go = 1'b0;
      end
    endcase
  end

  // Registered datapath and outputs; ADVANCE is folded into the last sample edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= 3'd0;
      settle_cnt <= 8'd0;
      sample_cnt <= 4'd0;
      ones_p0    <= 4'd0;
      code_sr_p0 <= 8'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      code_valid <= 1'b0;
      table_code <= 8'h00;
    end else begin
      done <= finish;
      if (go) begin
        idx        <= 3'd0;
        settle_cnt <= 8'd0;
        sample_cnt <= 4'd0;
        ones_p0    <= 4'd0;
        code_sr_p0 <= 8'd0;
        busy       <= 1'b1;
        code_valid <= 1'b0;
      end else if (cancel) begin
        idx        <= 3'd0;
        settle_cnt <= 8'd0;
        sample_cnt <= 4'd0;
        ones_p0    <= 4'd0;
        busy       <= 1'b0;
      end else if (state == SETTLE) begin
        settle_cnt <= settle_cnt + 8'd1;
      end else if (state == SAMPLE) begin
        if (vec_last) begin
          code_sr_p0 <= code_next;
          settle_cnt <= 8'd0;
          sample_cnt <= 4'd0;
          ones_p0    <= 4'd0;
          if (finish) begin
            idx        <= 3'd0;
            table_code <= code_next;
            code_valid <= 1'b1;
            busy       <= 1'b0;
          end else begin
            idx <= idx + 3'd1;
          end
        end else begin
          sample_cnt <= sample_cnt + 4'd1;
          ones_p0    <= ones_p0 + {3'b000, dut_out};
        end
      end
    end
  end

  assign in1 = idx[2];
  assign in2 = idx[1];
  assign in3 = idx[0];

endmodule
